// File: rtl/usb_pkg.sv
`default_nettype none
//==============================================================================
// Package  : usb_pkg
// Purpose  : PID constants, transaction FSM states and completion status codes
//            shared by the host transaction controller.
// Revision : 1.0  initial release
//==============================================================================
package usb_pkg;

    localparam int PID_W   = 4;
    localparam int RETRY_W = 4;

    localparam logic [PID_W-1:0] TOK_IN    = 4'b1001;
    localparam logic [PID_W-1:0] TOK_OUT   = 4'b0001;
    localparam logic [PID_W-1:0] PID_ACK   = 4'b0010;
    localparam logic [PID_W-1:0] PID_NAK   = 4'b1010;
    localparam logic [PID_W-1:0] PID_DATA0 = 4'b0011;
    localparam logic [PID_W-1:0] PID_DATA1 = 4'b1011;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_NAK     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_CRC     = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_TOKEN     = 4'd1,
        S_TOK_WAIT  = 4'd2,
        S_OUT_DATA  = 4'd3,
        S_WAIT_HS   = 4'd4,
        S_WAIT_DATA = 4'd5,
        S_SEND_ACK  = 4'd6,
        S_ACK_WAIT  = 4'd7,
        S_FIN       = 4'd8
    } xact_state_t;

endpackage
`default_nettype wire

// File: rtl/usb_host_xact_ctrl_if.sv
`default_nettype none
//==============================================================================
// Interface: usb_host_xact_ctrl_if
// Purpose  : Request/completion handshake plus link-layer PID/EOP strobes of
//            the host transaction controller.
// Revision : 1.0  initial release
//==============================================================================
interface usb_host_xact_ctrl_if;

    logic                       start;
    logic                       dir;
    logic [6:0]                 addr;
    logic [3:0]                 endp;
    logic                       busy;
    logic                       done;
    logic [1:0]                 status;
    logic                       tx_pid_en;
    logic [usb_pkg::PID_W-1:0]  tx_pid;
    logic [6:0]                 tx_addr;
    logic [3:0]                 tx_endp;
    logic                       tx_data_on;
    logic [usb_pkg::PID_W-1:0]  data_pid;
    logic                       tx_lp_eop_en;
    logic                       rx_pid_en;
    logic [usb_pkg::PID_W-1:0]  rx_pid;
    logic                       rx_lt_eop_en;
    logic                       crc16_err;
    logic                       time_out;

    modport master (
        input  start, dir, addr, endp,
        input  tx_lp_eop_en, rx_pid_en, rx_pid, rx_lt_eop_en, crc16_err, time_out,
        output busy, done, status,
        output tx_pid_en, tx_pid, tx_addr, tx_endp, tx_data_on, data_pid
    );

    modport slave (
        output start, dir, addr, endp,
        output tx_lp_eop_en, rx_pid_en, rx_pid, rx_lt_eop_en, crc16_err, time_out,
        input  busy, done, status,
        input  tx_pid_en, tx_pid, tx_addr, tx_endp, tx_data_on, data_pid
    );

endinterface
`default_nettype wire

// File: rtl/usb_retry_cnt.sv
`default_nettype none
//==============================================================================
// Module   : usb_retry_cnt
// Purpose  : Retry counter with clear, increment and exhausted flag.
// Revision : 1.0  initial release
//==============================================================================
module usb_retry_cnt
    import usb_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic exhausted
);

    localparam logic [RETRY_W-1:0] C_MAX = RETRY_W'(MAX_RETRY);

    logic [RETRY_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign exhausted = (r_cnt >= C_MAX);

endmodule
`default_nettype wire

// File: rtl/usb_host_xact_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : usb_host_xact_ctrl
// Purpose  : Host IN/OUT transaction initiator: token, data/handshake phase,
//            retries, DATA0/DATA1 toggles and completion status.
// Options  : USB_XACT_NAK_RETRY_EN - NAK consumes retries instead of ending.
// Revision : 1.0  initial release
//==============================================================================
module usb_host_xact_ctrl
    import usb_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    usb_host_xact_ctrl_if.master  bus
);

    xact_state_t        r_state;
    logic               r_dir;
    logic [6:0]         r_addr;
    logic [3:0]         r_endp;
    logic               r_busy;
    logic               r_done;
    logic [1:0]         r_status;
    logic               r_tx_pid_en;
    logic [PID_W-1:0]   r_tx_pid;
    logic               r_tx_data_on;
    logic               r_tog_in;
    logic               r_tog_out;
    logic [PID_W-1:0]   r_rx_pid;
    logic               r_cnt_clr;
    logic               r_cnt_inc;

    logic               w_exhausted;
    logic               w_fail;
    logic [1:0]         w_fail_st;
    logic [PID_W-1:0]   w_exp_in_pid;

    usb_retry_cnt #(.MAX_RETRY(MAX_RETRY)) u_retry_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (r_cnt_clr),
        .inc       (r_cnt_inc),
        .exhausted (w_exhausted)
    );

    assign w_exp_in_pid = r_tog_in ? PID_DATA1 : PID_DATA0;

    // Failed-attempt decode; a received PID takes precedence over a timeout.
    always_comb begin
        w_fail    = 1'b0;
        w_fail_st = ST_TIMEOUT;
        case (r_state)
            S_WAIT_HS: begin
                if (bus.rx_pid_en) begin
                    if (bus.rx_pid == PID_NAK) begin
`ifdef USB_XACT_NAK_RETRY_EN
                        w_fail    = 1'b1;
                        w_fail_st = ST_NAK;
`endif
                    end else if (bus.rx_pid != PID_ACK) begin
                        w_fail = 1'b1;
                    end
                end else if (bus.time_out) begin
                    w_fail = 1'b1;
                end
            end
            S_WAIT_DATA: begin
                if (bus.rx_pid_en) begin
`ifdef USB_XACT_NAK_RETRY_EN
                    if (bus.rx_pid == PID_NAK) begin
                        w_fail    = 1'b1;
                        w_fail_st = ST_NAK;
                    end
`endif
                end else if (bus.rx_lt_eop_en) begin
                    if (bus.crc16_err) begin
                        w_fail    = 1'b1;
                        w_fail_st = ST_CRC;
                    end
                end else if (bus.time_out) begin
                    w_fail = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_dir        <= 1'b0;
            r_addr       <= '0;
            r_endp       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_status     <= ST_OK;
            r_tx_pid_en  <= 1'b0;
            r_tx_pid     <= TOK_OUT;
            r_tx_data_on <= 1'b0;
            r_tog_in     <= 1'b0;
            r_tog_out    <= 1'b0;
            r_rx_pid     <= '0;
            r_cnt_clr    <= 1'b0;
            r_cnt_inc    <= 1'b0;
        end else begin
            r_tx_pid_en <= 1'b0;
            r_done      <= 1'b0;
            r_cnt_clr   <= 1'b0;
            r_cnt_inc   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_dir     <= bus.dir;
                        r_addr    <= bus.addr;
                        r_endp    <= bus.endp;
                        r_busy    <= 1'b1;
                        r_cnt_clr <= 1'b1;
                        r_state   <= S_TOKEN;
                    end
                end
                S_TOKEN: begin
                    r_tx_pid_en <= 1'b1;
                    r_tx_pid    <= r_dir ? TOK_IN : TOK_OUT;
                    r_state     <= S_TOK_WAIT;
                end
                S_TOK_WAIT: begin
                    if (bus.tx_lp_eop_en) begin
                        if (r_dir) begin
                            r_state <= S_WAIT_DATA;
                        end else begin
                            r_tx_data_on <= 1'b1;
                            r_state      <= S_OUT_DATA;
                        end
                    end
                end
                S_OUT_DATA: begin
                    if (bus.tx_lp_eop_en) begin
                        r_tx_data_on <= 1'b0;
                        r_state      <= S_WAIT_HS;
                    end
                end
                S_WAIT_HS: begin
                    if (bus.rx_pid_en && (bus.rx_pid == PID_ACK)) begin
                        r_tog_out <= ~r_tog_out;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_status  <= ST_OK;
                        r_state   <= S_FIN;
                    end
`ifndef USB_XACT_NAK_RETRY_EN
                    else if (bus.rx_pid_en && (bus.rx_pid == PID_NAK)) begin
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_status <= ST_NAK;
                        r_state  <= S_FIN;
                    end
`endif
                end
                S_WAIT_DATA: begin
                    if (bus.rx_pid_en) begin
                        r_rx_pid <= bus.rx_pid;
`ifndef USB_XACT_NAK_RETRY_EN
                        if (bus.rx_pid == PID_NAK) begin
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_status <= ST_NAK;
                            r_state  <= S_FIN;
                        end
`endif
                    end else if (bus.rx_lt_eop_en && !bus.crc16_err) begin
                        // A PID not matching the toggle is a duplicate: ACK it, keep the toggle.
                        if (r_rx_pid == w_exp_in_pid) begin
                            r_tog_in <= ~r_tog_in;
                        end
                        r_state <= S_SEND_ACK;
                    end
                end
                S_SEND_ACK: begin
                    r_tx_pid_en <= 1'b1;
                    r_tx_pid    <= PID_ACK;
                    r_state     <= S_ACK_WAIT;
                end
                S_ACK_WAIT: begin
                    if (bus.tx_lp_eop_en) begin
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_status <= ST_OK;
                        r_state  <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_fail) begin
                if (w_exhausted) begin
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_status <= w_fail_st;
                    r_state  <= S_FIN;
                end else begin
                    r_cnt_inc <= 1'b1;
                    r_state   <= S_TOKEN;
                end
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.status     = r_status;
    assign bus.tx_pid_en  = r_tx_pid_en;
    assign bus.tx_pid     = r_tx_pid;
    assign bus.tx_addr    = r_addr;
    assign bus.tx_endp    = r_endp;
    assign bus.tx_data_on = r_tx_data_on;
    assign bus.data_pid   = (r_dir ? r_tog_in : r_tog_out) ? PID_DATA1 : PID_DATA0;

endmodule
`default_nettype wire

// File: tb/tb_usb_host_xact_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_usb_host_xact_ctrl
// Purpose  : Directed self-checking bench for usb_host_xact_ctrl.
// Options  : USB_XACT_NAK_RETRY_EN selects the NAK-retry expectations.
// Revision : 1.0  initial release
//==============================================================================
module tb_usb_host_xact_ctrl;
    import usb_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   n_tok_in;
    int   n_tok_out;
    int   n_ack;

    usb_host_xact_ctrl_if bus ();

    usb_host_xact_ctrl #(.MAX_RETRY(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.tx_pid_en) begin
            if (bus.tx_pid == TOK_IN)  n_tok_in  = n_tok_in + 1;
            if (bus.tx_pid == TOK_OUT) n_tok_out = n_tok_out + 1;
            if (bus.tx_pid == PID_ACK) n_ack     = n_ack + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic d, input logic [6:0] a, input logic [3:0] e);
        bus.start = 1'b1; bus.dir = d; bus.addr = a; bus.endp = e;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_launch(input string tag, input logic [3:0] pid);
        int k = 0;
        while (!bus.tx_pid_en && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_launch"}, 32'(bus.tx_pid_en), 32'd1);
        chk({tag, "_pid"}, 32'(bus.tx_pid), 32'(pid));
    endtask

    task automatic wait_done(input string tag, input logic [1:0] st);
        int k = 0;
        while (!bus.done && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_status"}, 32'(bus.status), 32'(st));
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    task automatic tx_eop();
        bus.tx_lp_eop_en = 1'b1; tick(); bus.tx_lp_eop_en = 1'b0;
    endtask

    task automatic rx_pid_p(input logic [3:0] pid);
        bus.rx_pid_en = 1'b1; bus.rx_pid = pid; tick(); bus.rx_pid_en = 1'b0;
    endtask

    task automatic rx_eop(input logic crc);
        bus.rx_lt_eop_en = 1'b1; bus.crc16_err = crc; tick();
        bus.rx_lt_eop_en = 1'b0; bus.crc16_err = 1'b0;
    endtask

    task automatic tmo();
        bus.time_out = 1'b1; tick(); bus.time_out = 1'b0;
    endtask

    initial begin
        int s_in, s_out, s_ack, saw_done;
        n_cmp = 0; n_err = 0; n_tok_in = 0; n_tok_out = 0; n_ack = 0;
        bus.start = 0; bus.dir = 0; bus.addr = '0; bus.endp = '0;
        bus.tx_lp_eop_en = 0; bus.rx_pid_en = 0; bus.rx_pid = '0;
        bus.rx_lt_eop_en = 0; bus.crc16_err = 0; bus.time_out = 0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_status", 32'(bus.status), 32'd0);
        chk("rst_txpid", 32'(bus.tx_pid), 32'(TOK_OUT));
        chk("rst_datapid", 32'(bus.data_pid), 32'(PID_DATA0));
        chk("rst_txen", 32'(bus.tx_pid_en), 32'd0);
        rst_n = 1'b1;
        tick();

        // OUT with ACK; also latency and start-while-busy
        do_start(1'b0, 7'h05, 4'h1);
        chk("out_busy_lat", 32'(bus.busy), 32'd1);
        chk("out_txen_early", 32'(bus.tx_pid_en), 32'd0);
        tick();
        chk("out_txen_lat", 32'(bus.tx_pid_en), 32'd1);
        chk("out_tok", 32'(bus.tx_pid), 32'(TOK_OUT));
        chk("out_addr", 32'(bus.tx_addr), 32'h05);
        chk("out_endp", 32'(bus.tx_endp), 32'h1);
        tx_eop();
        chk("out_data_on", 32'(bus.tx_data_on), 32'd1);
        do_start(1'b1, 7'h7f, 4'hf);
        chk("out_ign_addr", 32'(bus.tx_addr), 32'h05);
        tx_eop();
        chk("out_data_off", 32'(bus.tx_data_on), 32'd0);
        rx_pid_p(PID_ACK);
        chk("out_done_lat", 32'(bus.done), 32'd1);
        wait_done("out_ack", ST_OK);
        chk("out_tog", 32'(bus.data_pid), 32'(PID_DATA1));

        // IN with DATA0, then duplicate DATA0
        s_ack = n_ack;
        do_start(1'b1, 7'h12, 4'h3);
        chk("in_datapid", 32'(bus.data_pid), 32'(PID_DATA0));
        wait_launch("in1_tok", TOK_IN);
        chk("in_addr", 32'(bus.tx_addr), 32'h12);
        tx_eop();
        rx_pid_p(PID_DATA0);
        rx_eop(1'b0);
        wait_launch("in1_ack", PID_ACK);
        tx_eop();
        wait_done("in1", ST_OK);
        chk("in1_tog", 32'(bus.data_pid), 32'(PID_DATA1));
        do_start(1'b1, 7'h12, 4'h3);
        wait_launch("in2_tok", TOK_IN);
        tx_eop();
        rx_pid_p(PID_DATA0);
        rx_eop(1'b0);
        wait_launch("in2_ack", PID_ACK);
        tx_eop();
        wait_done("in2_dup", ST_OK);
        chk("in2_tog", 32'(bus.data_pid), 32'(PID_DATA1));
        chk("in_ack_cnt", 32'(n_ack - s_ack), 32'd2);

        // OUT timing out on every attempt
        s_out = n_tok_out;
        do_start(1'b0, 7'h05, 4'h1);
        for (int a = 0; a < 4; a++) begin
            wait_launch("to_tok", TOK_OUT);
            tx_eop();
            tx_eop();
            tmo();
            if (a == 0) begin
                tick();
                chk("to_retry_lat", 32'(bus.tx_pid_en), 32'd1);
            end
        end
        wait_done("to", ST_TIMEOUT);
        chk("to_tok_cnt", 32'(n_tok_out - s_out), 32'd4);
        chk("to_tog", 32'(bus.data_pid), 32'(PID_DATA1));

        // IN with two CRC errors then clean DATA1
        s_in = n_tok_in; s_ack = n_ack;
        do_start(1'b1, 7'h21, 4'h2);
        for (int a = 0; a < 3; a++) begin
            wait_launch("crc_tok", TOK_IN);
            tx_eop();
            rx_pid_p(PID_DATA1);
            rx_eop(a < 2);
        end
        wait_launch("crc_ack", PID_ACK);
        tx_eop();
        wait_done("crc", ST_OK);
        chk("crc_tok_cnt", 32'(n_tok_in - s_in), 32'd3);
        chk("crc_ack_cnt", 32'(n_ack - s_ack), 32'd1);
        chk("crc_tog", 32'(bus.data_pid), 32'(PID_DATA0));

        // NAK in WAIT_HS
        s_out = n_tok_out;
        do_start(1'b0, 7'h05, 4'h1);
`ifdef USB_XACT_NAK_RETRY_EN
        for (int a = 0; a < 4; a++) begin
`else
        for (int a = 0; a < 1; a++) begin
`endif
            wait_launch("nak_tok", TOK_OUT);
            tx_eop();
            tx_eop();
            rx_pid_p(PID_NAK);
        end
        chk("nak_done_lat", 32'(bus.done), 32'd1);
        wait_done("nak", ST_NAK);
`ifdef USB_XACT_NAK_RETRY_EN
        chk("nak_tok_cnt", 32'(n_tok_out - s_out), 32'd4);
`else
        chk("nak_tok_cnt", 32'(n_tok_out - s_out), 32'd1);
`endif

        // Reset while waiting for IN data
        do_start(1'b1, 7'h33, 4'h4);
        wait_launch("rst_tok", TOK_IN);
        tx_eop();
        chk("rst_pre_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_dataon", 32'(bus.tx_data_on), 32'd0);
        chk("rst_mid_addr", 32'(bus.tx_addr), 32'h0);
        saw_done = 0;
        repeat (2) begin
            tick();
            if (bus.done) saw_done = 1;
        end
        rst_n = 1'b1;
        repeat (2) begin
            tick();
            if (bus.done) saw_done = 1;
        end
        chk("rst_no_done", 32'(saw_done), 32'd0);
        do_start(1'b0, 7'h05, 4'h1);
        chk("post_rst_datapid", 32'(bus.data_pid), 32'(PID_DATA0));
        wait_launch("post_rst_tok", TOK_OUT);
        tx_eop();
        tx_eop();
        rx_pid_p(PID_ACK);
        wait_done("post_rst", ST_OK);
        chk("post_rst_tog", 32'(bus.data_pid), 32'(PID_DATA1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_host_xact_ctrl.md
# usb_host_xact_ctrl

Host-side USB transaction initiator for the link layer. It accepts one IN or OUT request at a time and drives the token/handshake transmitter. It then follows the response phase from the receive-side PID and EOP strobes and the link timeout flag, retries failed attempts, maintains DATA0/DATA1 toggles, and reports a completion status. It sits above the link controller and drives the same PID/EOP handshake that the link controller monitors.

## Interface
- MAX_RETRY, 3: extra attempts after the first failure; range 0-15.
- TOK_IN, 4'b1001; TOK_OUT, 4'b0001; PID_ACK, 4'b0010; PID_NAK, 4'b1010; PID_DATA0, 4'b0011; PID_DATA1, 4'b1011: PID constants.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; sampled only in IDLE.
- dir  in  1  1 = IN, 0 = OUT; captured with start.
- addr  in  7  device address; captured with start.
- endp  in  4  endpoint; captured with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- status  out  2  valid with done, held until next done: 00 OK, 01 NAK, 10 timeout exhausted, 11 CRC error exhausted.
- tx_pid_en  out  1  one-cycle pulse that launches a token or handshake packet.
- tx_pid  out  4  PID for tx_pid_en; held until the next launch.
- tx_addr, tx_endp  out  7/4  token fields; equal to the captured values.
- tx_data_on  out  1  OUT data phase request to the data transmitter.
- data_pid  out  4  DATA0/DATA1 for the current transfer.
- tx_lp_eop_en  in  1  pulse at the end of any transmitted packet.
- rx_pid_en  in  1  pulse when a received PID is complete.
- rx_pid  in  4  received PID.
- rx_lt_eop_en  in  1  pulse at the end of a received data packet.
- crc16_err  in  1  valid with rx_lt_eop_en.
- time_out  in  1  one-cycle pulse from the link timeout.

## Operation
- States: IDLE, TOKEN, TOK_WAIT, OUT_DATA, WAIT_HS, WAIT_DATA, SEND_ACK, ACK_WAIT, FIN.
- IDLE, start=1:
  - Capture dir, addr and endp; clear retry_cnt; go to TOKEN.
- TOKEN:
  - Pulse tx_pid_en for one cycle with tx_pid = TOK_IN or TOK_OUT; go to TOK_WAIT.
- TOK_WAIT, tx_lp_eop_en:
  - OUT: go to OUT_DATA.
  - IN: go to WAIT_DATA.
- OUT_DATA:
  - Raise tx_data_on.
  - On tx_lp_eop_en, drop tx_data_on and go to WAIT_HS.
- WAIT_HS:
  - rx_pid_en with ACK: flip tog_out, status 00, go to FIN.
  - NAK: handled per Configuration.
  - time_out, or any other PID: treat as a failed attempt.
- WAIT_DATA:
  - rx_pid_en with NAK: handled per Configuration.
  - rx_lt_eop_en with crc16_err=0: go to SEND_ACK.
    - Flip tog_in only if the received data PID matches tog_in.
    - A mismatched PID is a duplicate: it is still ACKed, the toggle is not flipped, and the transfer ends with status 00.
  - rx_lt_eop_en with crc16_err=1: failed attempt; no ACK is sent.
  - time_out: failed attempt.
- SEND_ACK:
  - Pulse tx_pid_en with PID_ACK; go to ACK_WAIT.
- ACK_WAIT, tx_lp_eop_en:
  - Status 00; go to FIN.
- Failed attempt:
  - If retry_cnt < MAX_RETRY: increment retry_cnt, return to TOKEN.
  - Otherwise go to FIN with status 10 (last failure was a timeout) or 11 (last failure was a CRC error).
- FIN:
  - Pulse done; return to IDLE.
- Toggles:
  - tog_in and tog_out each reset to 0.
  - data_pid = PID_DATA1 when the relevant toggle is 1, else PID_DATA0.
- Simultaneous events:
  - rx_pid_en and time_out in the same cycle: the PID wins.
  - start while busy: ignored; no queueing.

## Timing
- Reset: all outputs 0, state IDLE, toggles 0.
  - Exceptions: tx_pid is TOK_OUT; data_pid is PID_DATA0.
- Latency from start:
  - busy rises 1 cycle after start.
  - tx_pid_en rises 2 cycles after start.
- done asserts 1 cycle after the terminal event is sampled; busy falls in the same cycle as done.
- The next start is accepted in the cycle after done.
- A retry re-issues tx_pid_en 2 cycles after the failure event.
- Reset mid-transfer: immediate return to IDLE; toggles cleared; no done pulse.

## Configuration
- USB_XACT_NAK_RETRY_EN defined: NAK counts as a failed attempt and consumes retries. When retries are exhausted, status is 01.
- USB_XACT_NAK_RETRY_EN undefined: NAK ends the transfer immediately with status 01; retry_cnt is untouched.

## Structure
- Shared package usb_pkg:
  - PID constants.
  - State enum.
  - Status codes.
- One optional sub-module, usb_retry_cnt: counter with clear, increment and exhausted flag.
- No other hierarchy.

## Test plan
- OUT, MAX_RETRY=3: start dir=0 addr=7'h05 endp=4'h1 -> tx_pid=0001; after the two tx_lp_eop_en pulses, ACK -> done, status 00, tog_out=1.
- IN with DATA0 and clean CRC -> tx_pid_en with PID_ACK, done, status 00. A second IN returning DATA0 again -> ACKed, tog_in stays 1, status 00.
- OUT with time_out on every attempt -> exactly 4 TOK_OUT launches, then done, status 10.
- IN, crc16_err=1 twice then clean -> 3 TOK_IN launches, no ACK on the bad packets, status 00.
- NAK in WAIT_HS:
  - macro undefined -> done next cycle, status 01, one token launched.
  - macro defined -> 4 attempts, then status 01.
- rst_n asserted in WAIT_DATA -> busy and tx_data_on drop immediately; no done; a fresh start works.
